q2_display_io: RTL and testbench
================================

// Module: q2_display_io
// PURPOSE
//  Synthesizable memory-mapped console peripheral for the q2 CPU. It replaces the bench-only display/key model.
//  Decodes wrm/rdm cycles at IO_ADDR and holds a ROWS x COLS character buffer with a cursor.
//  Runs cursor/clear/newline commands and debounces an active-low key matrix for CPU reads.
//  Gives an independent scan port for an LCD/VGA driver.
// PARAMETERS
//  W          12      data bus width (>= 9)
//  AW         12      address bus width
//  IO_ADDR    12'hFFF decoded I/O address
//  ROWS       2       display rows
//  COLS       64      columns per row; CELLS = ROWS*COLS, CELLS <= 128
//  NKEYS      10      key inputs (NKEYS <= W-1)
//  DEB_CYCLES 4       consecutive stable samples before a key change is accepted (>= 1)
// PORTS
//  clk        in   1        clock, all state on rising edge
//  rst        in   1        asynchronous reset, active-low (0 = reset)
//  abus       in   AW       CPU address
//  din        in   W        CPU write data
//  dout       out  W        CPU read data, valid while rdm && hit
//  wrm        in   1        CPU write strobe (level)
//  rdm        in   1        CPU read strobe (level)
//  keys_n     in   NKEYS    raw key inputs, 0 = pressed, asynchronous
//  scan_addr  in   7        display-driver cell index
//  scan_data  out  8        character at scan_addr, 1-cycle latency
//  busy       out  1        clear sweep in progress
//  cursor     out  7        current cursor cell
// BEHAVIOUR
//  Reset: cursor=0, scan_data=0, busy=1, keys_db=all released, wr_q=0, drop=0; FSM=CLEAR, sweep index=0.
//  Buffer RAM contents are not reset.
//  hit = (abus == IO_ADDR). A write event is wrm && !wr_q && hit, where wr_q is wrm delayed one clk.
//  One event per strobe regardless of strobe length.
//  Write decode, acted on in the cycle after the event is detected:
//   din[8]=0: character. Store c=din[7:0] at cursor; c<8'h20 or c>8'h7E stores 8'h3F.
//    Then cursor=cursor+1; CELLS-1 wraps to 0.
//   din[8]=1,din[7]=1: cursor = din[6:0] mod CELLS.
//   din[8]=1,din[7]=0,din[0]=1: clear. Enter CLEAR.
//   din[8]=1,din[7]=0,din[1]=1,din[0]=0: newline. Cursor = start of next row; last row wraps to cell 0.
//   Any other command: no effect.
//  FSM IDLE/CLEAR:
//   CLEAR writes 8'h20 to sweep index, one cell per clk, for exactly CELLS cycles.
//   Then cursor=0, busy=0, next state IDLE.
//   busy is high for every CLEAR cycle, falling in the clk after the last cell is written.
//  A write event while busy is dropped (no buffer or cursor change) and sets sticky drop.
//  drop clears on the next CPU read hit.
//  Read: dout combinational. dout[NKEYS-1:0] = keys_db (0 = pressed); dout[W-1] = ~busy; dout[W-2] = ~drop.
//  All other bits are 1. Idle value with W=12 is 12'hFFF. dout = 0 when !(rdm && hit).
//  Key path: keys_n passes through a 2-flop synchroniser, then a per-key counter.
//  keys_db[k] takes the synchronised value once that value has differed from keys_db[k] for DEB_CYCLES consecutive clks.
//  Any bounce restarts that key's count.
//  Scan port: scan_data <= buf[scan_addr mod CELLS] each clk, independent of CPU writes.
//  On a same-cell same-cycle write the old value is returned.
//  Async reset mid-CLEAR or mid-write restarts the CLEAR sweep from index 0 after rst releases.
// TESTING
//  1. Release reset, hold bus idle -> busy=1 for exactly 128 clks. Then every scan_addr 0..127 reads 8'h20.
//  2. Write 0x048,0x069 -> cells 0,1 = 'H','i', cursor=2. Write 0x007 -> cell 2 = 8'h3F.
//  3. Write 0x1BF (set cursor 63), then 0x041,0x042 -> cell 63='A', cell 64='B'. Write 0x1FF then 0x043 -> cell 127='C', cursor wraps to 0.
//  4. Write 0x185, then 0x102 -> cursor=64. Write 0x102 again -> cursor=0. Write 0x101, then a character during busy -> char dropped, read shows dout[10]=0; next read shows dout[10]=1.
//  5. Hold keys_n[9]=0 with 2 glitches, then stable -> dout==12'hDFF only after 2+DEB_CYCLES stable clks. Release -> 12'hFFF.
//  6. Assert rst mid-sweep at index 40 -> after release, sweep restarts, busy high 128 more clks, cursor=0.

Source files
------------

// File: rtl/q2_display_io.sv
// Memory-mapped console peripheral for the q2 CPU: character buffer with cursor,
// clear/newline commands, debounced key matrix and an independent display scan port.
module q2_display_io #(
  parameter int             W          = 12,
  parameter int             AW         = 12,
  parameter logic [AW-1:0]  IO_ADDR    = 12'hFFF,
  parameter int             ROWS       = 2,
  parameter int             COLS       = 64,
  parameter int             NKEYS      = 10,
  parameter int             DEB_CYCLES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [AW-1:0]    abus_i,
  input  logic [W-1:0]     din_i,
  output logic [W-1:0]     dout_o,
  input  logic             wrm_i,
  input  logic             rdm_i,
  input  logic [NKEYS-1:0] keys_ni,
  input  logic [6:0]       scan_addr_i,
  output logic [7:0]       scan_data_o,
  output logic             busy_o,
  output logic [6:0]       cursor_o
);

  localparam int          CELLS    = ROWS * COLS;
  localparam logic [7:0]  CELLS8   = 8'(CELLS);
  localparam logic [7:0]  COLS8    = 8'(COLS);
  localparam logic [7:0]  LASTROW8 = 8'((ROWS - 1) * COLS);
  localparam logic [6:0]  LAST7    = 7'(CELLS - 1);
  localparam int          CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  function automatic logic [7:0] printable(input logic [7:0] c);
    if (c < 8'h20 || c > 8'h7E) begin
      printable = 8'h3F;
    end else begin
      printable = c;
    end
  endfunction

  state_t          state_q, state_d;
  logic [6:0]      idx_q, idx_d;
  logic [6:0]      cursor_q, cursor_d;
  logic            busy_q, busy_d;
  logic            drop_q, drop_d;
  logic            wr_q, pend_q;
  logic [8:0]      pdata_q;
  logic [7:0]      scan_data_q;
  logic [NKEYS-1:0] sync1_q, sync2_q, db_q, db_d;
  logic [CW-1:0]   cnt_q [NKEYS];
  logic [CW-1:0]   cnt_d [NKEYS];
  logic [7:0]      mem_q [CELLS];

  logic            hit_s, wr_ev_s, mem_we_s;
  logic [6:0]      mem_waddr_s;
  logic [7:0]      mem_wdata_s, set8_s, nl8_s, scan8_s;
  logic [W-1:0]    dout_s;
  logic            unused_s;

  assign hit_s   = (abus_i == IO_ADDR);
  assign wr_ev_s = wrm_i && !wr_q && hit_s;
  assign set8_s  = {1'b0, pdata_q[6:0]} % CELLS8;
  assign nl8_s   = (({1'b0, cursor_q} / COLS8) + 8'd1) * COLS8;
  assign scan8_s = {1'b0, scan_addr_i} % CELLS8;
  assign unused_s = ^{din_i[W-1:9], set8_s[7], nl8_s[7], scan8_s[7]};

  // Command execution and clear sweep; a pending write seen during CLEAR is dropped
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cursor_d    = cursor_q;
    drop_d      = drop_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = idx_q;
    mem_wdata_s = 8'h20;
    if (rdm_i && hit_s) begin
      drop_d = 1'b0;
    end else begin
      drop_d = drop_q;
    end
    case (state_q)
      CLEAR: begin
        mem_we_s = 1'b1;
        if (pend_q) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_d;
        end
        if (idx_q == LAST7) begin
          state_d  = IDLE;
          idx_d    = 7'd0;
          cursor_d = 7'd0;
        end else begin
          idx_d = idx_q + 7'd1;
        end
      end
      IDLE: begin
        if (!pend_q) begin
          state_d = IDLE;
        end else if (!pdata_q[8]) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = cursor_q;
          mem_wdata_s = printable(pdata_q[7:0]);
          cursor_d    = (cursor_q == LAST7) ? 7'd0 : cursor_q + 7'd1;
        end else if (pdata_q[7]) begin
          cursor_d = set8_s[6:0];
        end else if (pdata_q[0]) begin
          state_d = CLEAR;
          idx_d   = 7'd0;
        end else if (pdata_q[1]) begin
          cursor_d = ({1'b0, cursor_q} >= LASTROW8) ? 7'd0 : nl8_s[6:0];
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = CLEAR;
        idx_d   = 7'd0;
      end
    endcase
    busy_d = (state_d == CLEAR);
  end

  // Per-key debounce: accept a new level only after it persists DEB_CYCLES clocks
  always_comb begin
    db_d = db_q;
    for (int k = 0; k < NKEYS; k++) begin
      cnt_d[k] = '0;
      if (sync2_q[k] != db_q[k]) begin
        if (cnt_q[k] == CNT_LAST) begin
          db_d[k] = sync2_q[k];
        end else begin
          cnt_d[k] = cnt_q[k] + CW'(1);
        end
      end else begin
        cnt_d[k] = '0;
      end
    end
  end

  // CPU read data, driven only during a read hit
  always_comb begin
    dout_s = '0;
    if (rdm_i && hit_s) begin
      dout_s            = '1;
      dout_s[NKEYS-1:0] = db_q;
      dout_s[W-1]       = ~busy_q;
      dout_s[W-2]       = ~drop_q;
    end else begin
      dout_s = '0;
    end
  end

  // Control, key and scan registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= CLEAR;
      idx_q       <= 7'd0;
      cursor_q    <= 7'd0;
      busy_q      <= 1'b1;
      drop_q      <= 1'b0;
      wr_q        <= 1'b0;
      pend_q      <= 1'b0;
      pdata_q     <= 9'd0;
      scan_data_q <= 8'd0;
      sync1_q     <= '1;
      sync2_q     <= '1;
      db_q        <= '1;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cursor_q    <= cursor_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      wr_q        <= wrm_i;
      pend_q      <= wr_ev_s;
      pdata_q     <= din_i[8:0];
      scan_data_q <= mem_q[scan8_s[6:0]];
      sync1_q     <= keys_ni;
      sync2_q     <= sync1_q;
      db_q        <= db_d;
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  // Character buffer; contents survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  assign dout_o      = dout_s;
  assign scan_data_o = scan_data_q;
  assign busy_o      = busy_q;
  assign cursor_o    = cursor_q;

endmodule

// File: tb/tb_q2_display_io.sv
// Directed bench for q2_display_io: clear sweep, character/command writes, drop flag,
// key debounce timing and reset during a sweep.
module tb_q2_display_io;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] abus;
  logic [11:0] din;
  logic [11:0] dout;
  logic        wrm;
  logic        rdm;
  logic [9:0]  keys_n;
  logic [6:0]  scan_addr;
  logic [7:0]  scan_data;
  logic        busy;
  logic [6:0]  cursor;

  int checks = 0;
  int errors = 0;
  int n;
  int nbad;

  always #5 clk = ~clk;

  q2_display_io dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .abus_i      (abus),
    .din_i       (din),
    .dout_o      (dout),
    .wrm_i       (wrm),
    .rdm_i       (rdm),
    .keys_ni     (keys_n),
    .scan_addr_i (scan_addr),
    .scan_data_o (scan_data),
    .busy_o      (busy),
    .cursor_o    (cursor)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_wr(input logic [11:0] d);
    @(negedge clk);
    abus = 12'hFFF;
    din  = d;
    wrm  = 1'b1;
    @(negedge clk);
    wrm = 1'b0;
    @(negedge clk);
  endtask

  task automatic scan_chk(input string tag, input logic [6:0] a, input logic [7:0] exp);
    scan_addr = a;
    @(negedge clk);
    chk(tag, {24'd0, scan_data}, {24'd0, exp});
  endtask

  task automatic busy_len(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  initial begin
    rst_n = 1'b0; abus = 12'h000; din = 12'h000; wrm = 1'b0; rdm = 1'b0;
    keys_n = 10'h3FF; scan_addr = 7'd0;

    // reset state
    #22;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_cursor", {25'd0, cursor}, 32'd0);
    chk("rst_scan", {24'd0, scan_data}, 32'd0);
    chk("rst_dout", {20'd0, dout}, 32'd0);

    // 1: sweep length after release, then every cell blank
    @(negedge clk);
    rst_n = 1'b1;
    busy_len(n);
    chk("sweep_len", n, 32'd128);
    nbad = 0;
    for (int i = 0; i < 128; i++) begin
      scan_addr = 7'(i);
      @(negedge clk);
      if (scan_data !== 8'h20) nbad++;
    end
    chk("all_blank", nbad, 32'd0);
    chk("cursor_after_clear", {25'd0, cursor}, 32'd0);

    // 2: plain characters and non-printable substitution
    cpu_wr(12'h048);
    cpu_wr(12'h069);
    chk("cursor_hi", {25'd0, cursor}, 32'd2);
    scan_chk("cell0_H", 7'd0, 8'h48);
    scan_chk("cell1_i", 7'd1, 8'h69);
    cpu_wr(12'h007);
    scan_chk("cell2_ctrl", 7'd2, 8'h3F);

    // 3: set cursor, row crossing, wrap at last cell
    cpu_wr(12'h1BF);
    chk("cursor_set63", {25'd0, cursor}, 32'd63);
    cpu_wr(12'h041);
    cpu_wr(12'h042);
    scan_chk("cell63_A", 7'd63, 8'h41);
    scan_chk("cell64_B", 7'd64, 8'h42);
    cpu_wr(12'h1FF);
    cpu_wr(12'h043);
    scan_chk("cell127_C", 7'd127, 8'h43);
    chk("cursor_wrap", {25'd0, cursor}, 32'd0);
    cpu_wr(12'h07F);
    cpu_wr(12'h07E);
    scan_chk("cell0_7F", 7'd0, 8'h3F);
    scan_chk("cell1_7E", 7'd1, 8'h7E);

    // 4: newline, no-op command, clear with dropped write
    cpu_wr(12'h185);
    chk("cursor_set5", {25'd0, cursor}, 32'd5);
    cpu_wr(12'h102);
    chk("newline_row1", {25'd0, cursor}, 32'd64);
    cpu_wr(12'h102);
    chk("newline_wrap", {25'd0, cursor}, 32'd0);
    cpu_wr(12'h18A);
    cpu_wr(12'h100);
    chk("noop_cmd", {25'd0, cursor}, 32'd10);
    cpu_wr(12'h101);
    chk("clear_busy", {31'd0, busy}, 32'd1);
    cpu_wr(12'h041);
    chk("drop_cursor", {25'd0, cursor}, 32'd10);
    abus = 12'hFFF; rdm = 1'b1; #1;
    chk("read_drop", {20'd0, dout}, 32'h3FF);
    @(negedge clk);
    rdm = 1'b0;
    @(negedge clk);
    rdm = 1'b1; #1;
    chk("read_drop_clr", {20'd0, dout}, 32'h7FF);
    @(negedge clk);
    rdm = 1'b0;
    busy_len(n);
    chk("clear_done", {31'd0, busy}, 32'd0);
    chk("clear_cursor", {25'd0, cursor}, 32'd0);
    scan_chk("cell0_cleared", 7'd0, 8'h20);
    abus = 12'h123; rdm = 1'b1; #1;
    chk("read_miss", {20'd0, dout}, 32'h000);
    abus = 12'hFFF; #1;
    chk("read_idle", {20'd0, dout}, 32'hFFF);

    // 5: key 9 press with two glitches, then release
    @(negedge clk); keys_n[9] = 1'b0;
    @(negedge clk); keys_n[9] = 1'b1;
    @(negedge clk); keys_n[9] = 1'b0;
    @(negedge clk); keys_n[9] = 1'b1;
    @(negedge clk); keys_n[9] = 1'b0;
    repeat (5) @(negedge clk);
    chk("key_not_yet", {20'd0, dout}, 32'hFFF);
    @(negedge clk);
    chk("key_pressed", {20'd0, dout}, 32'hDFF);
    keys_n[9] = 1'b1;
    repeat (5) @(negedge clk);
    chk("key_still_held", {20'd0, dout}, 32'hDFF);
    @(negedge clk);
    chk("key_released", {20'd0, dout}, 32'hFFF);
    rdm = 1'b0;

    // 6: reset at sweep index 40 restarts the full sweep
    cpu_wr(12'h187);
    cpu_wr(12'h101);
    repeat (40) @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    chk("mid_rst_cursor", {25'd0, cursor}, 32'd0);
    chk("mid_rst_scan", {24'd0, scan_data}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_len(n);
    chk("resweep_len", n, 32'd128);
    chk("resweep_cursor", {25'd0, cursor}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
